// File: rtl/btn_ui_pkg.sv
// Shared constants for the pushbutton UI block: button indices and
// board-default timing parameters (100 MHz clock).
package btn_ui_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_DEC = 0;
  localparam int BTN_INC = 1;
  localparam int BTN_DIM = 2;
  localparam int BTN_BRT = 3;

  localparam int DEF_DEBOUNCE_CYC = 20_000_000;
  localparam int DEF_PWM_PERIOD   = 1_000_000;
  localparam int DEF_LEVELS       = 5;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, stability timer, press pulse.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   btn_raw  in  asynchronous active-high pushbutton
//   press    out one-cycle pulse on an accepted debounced 0->1 edge
//
// The stability timer is a down-counter reloaded whenever the synchronised
// level is about to change; when it reaches zero the current level has held
// for DEBOUNCE_CYC cycles and becomes the debounced level.
// After reset the button is not armed: a press is only reported once a
// released level has itself been debounced, so a button held through reset
// has to be let go and pressed again.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          db_q,    db_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    armed_d = armed_q;
    press_d = 1'b0;

    // sync1 != sync2 means sync2 takes a new value at this edge
    if (sync1_q != sync2_q) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (cnt_q == '0) begin
      db_d = sync2_q;
      if (!sync2_q) begin
        armed_d = 1'b1;
      end
      press_d = sync2_q & ~db_q & armed_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= RELOAD;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/btn_counter_dimmer.sv
// Pushbutton UI: saturating signed counter (dec/inc buttons) shown on LEDs,
// with LED brightness (dim/brighten buttons) applied through a PWM gate.
// Ports:
//   clk         in  system clock
//   reset_n     in  synchronous active-low reset
//   usr_btn     in  raw pushbuttons [DEC, INC, DIM, BRT] = bits [0..3]
//   usr_led     out counter value gated by PWM (registered)
//   count       out current counter value, two's complement
//   brightness  out current brightness level 0..LEVELS-1
//   pwm_on      out current PWM phase, 1 = LEDs lit
module btn_counter_dimmer
  import btn_ui_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int LEVELS       = DEF_LEVELS,
  parameter int BR_W         = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_BTN-1:0]      usr_btn,
  output logic [CNT_W-1:0]        usr_led,
  output logic signed [CNT_W-1:0] count,
  output logic [BR_W-1:0]         brightness,
  output logic                    pwm_on
);

  // wide enough to hold PWM_PERIOD itself (on_cnt of the top level)
  localparam int TW = $clog2(PWM_PERIOD + 1);

  localparam logic [TW-1:0]          TICK_LAST = TW'(PWM_PERIOD - 1);
  localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [BR_W-1:0]         BR_MAX   = BR_W'(LEVELS - 1);

  // Level 0 keeps a small floor so the display never goes fully dark.
  function automatic logic [TW-1:0] on_cnt_of(input logic [BR_W-1:0] k);
    int v;
    if (k == '0) begin
      v = PWM_PERIOD / 20;
    end else begin
      v = int'(k) * PWM_PERIOD / (LEVELS - 1);
    end
    return TW'(v);
  endfunction

  logic [NUM_BTN-1:0] press;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_raw(usr_btn[i]),
      .press  (press[i])
    );
  end

  logic signed [CNT_W-1:0] count_q,      count_d;
  logic [BR_W-1:0]         brightness_q, brightness_d;
  logic [TW-1:0]           tick_q,       tick_d;
  logic [TW-1:0]           on_cnt_q,     on_cnt_d;
  logic                    pwm_on_q,     pwm_on_d;
  logic [CNT_W-1:0]        usr_led_q,    usr_led_d;

  always_comb begin
    count_d      = count_q;
    brightness_d = brightness_q;
    tick_d       = tick_q;
    on_cnt_d     = on_cnt_q;
    pwm_on_d     = pwm_on_q;
    usr_led_d    = usr_led_q;

    if (press[BTN_INC] && !press[BTN_DEC] && count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end else if (press[BTN_DEC] && !press[BTN_INC] && count_q != CNT_MIN) begin
      count_d = count_q - CNT_W'(1);
    end

    if (press[BTN_BRT] && !press[BTN_DIM] && brightness_q != BR_MAX) begin
      brightness_d = brightness_q + BR_W'(1);
    end else if (press[BTN_DIM] && !press[BTN_BRT] && brightness_q != '0) begin
      brightness_d = brightness_q - BR_W'(1);
    end

    // on_cnt only changes at the period boundary, so every period is whole
    if (tick_q == TICK_LAST) begin
      tick_d   = '0;
      on_cnt_d = on_cnt_of(brightness_q);
    end else begin
      tick_d   = tick_q + TW'(1);
    end

    // pwm_on_q is aligned with tick_q
    pwm_on_d  = (tick_d < on_cnt_d);
    usr_led_d = pwm_on_q ? count_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q      <= '0;
      brightness_q <= '0;
      tick_q       <= '0;
      on_cnt_q     <= on_cnt_of('0);
      pwm_on_q     <= 1'b0;
      usr_led_q    <= '0;
    end else begin
      count_q      <= count_d;
      brightness_q <= brightness_d;
      tick_q       <= tick_d;
      on_cnt_q     <= on_cnt_d;
      pwm_on_q     <= pwm_on_d;
      usr_led_q    <= usr_led_d;
    end
  end

  assign count      = count_q;
  assign brightness = brightness_q;
  assign pwm_on     = pwm_on_q;
  assign usr_led    = usr_led_q;

endmodule

// File: tb/tb_btn_counter_dimmer.sv
module tb_btn_counter_dimmer;

  localparam int CNT_W        = 4;
  localparam int DEBOUNCE_CYC = 4;
  localparam int PWM_PERIOD   = 20;
  localparam int LEVELS       = 5;
  localparam int BR_W         = 3;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [3:0]              usr_btn;
  logic [CNT_W-1:0]        usr_led;
  logic signed [CNT_W-1:0] count;
  logic [BR_W-1:0]         brightness;
  logic                    pwm_on;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_counter_dimmer #(
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .PWM_PERIOD  (PWM_PERIOD),
    .LEVELS      (LEVELS),
    .BR_W        (BR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .usr_btn   (usr_btn),
    .usr_led   (usr_led),
    .count     (count),
    .brightness(brightness),
    .pwm_on    (pwm_on)
  );

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hold the button pattern 10 cycles, then release 10 cycles
  task automatic press(input logic [3:0] m);
    usr_btn = m;
    wait_cyc(10);
    usr_btn = 4'b0000;
    wait_cyc(10);
  endtask

  task automatic duty(output int d);
    d = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (pwm_on) d++;
    end
  endtask

  task automatic test_reset;
    int d;
    reset_n = 1'b0;
    usr_btn = 4'b0000;
    wait_cyc(3);
    n_cmp++; if (count !== 4'sd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (brightness !== 3'd0) begin n_fail++; $display("FAIL reset_brightness got %0d want 0", brightness); end
    n_cmp++; if (usr_led !== 4'b0000) begin n_fail++; $display("FAIL reset_usr_led got %b want 0000", usr_led); end
    n_cmp++; if (pwm_on !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_on got %b want 0", pwm_on); end
    reset_n = 1'b1;
    wait_cyc(40);
    duty(d);
    n_cmp++; if (d != 1) begin n_fail++; $display("FAIL duty_level0 got %0d want 1", d); end
    n_cmp++; if (usr_led !== 4'b0000) begin n_fail++; $display("FAIL idle_usr_led got %b want 0000", usr_led); end
  endtask

  task automatic test_count_sat;
    logic signed [CNT_W-1:0] e;
    for (int i = 1; i <= 9; i++) begin
      press(4'b0010);
      e = (i > 7) ? 4'sd7 : CNT_W'(i);
      n_cmp++; if (count !== e) begin n_fail++; $display("FAIL inc_%0d got %0d want %0d", i, count, e); end
    end
    for (int i = 1; i <= 17; i++) begin
      press(4'b0001);
      e = (7 - i < -8) ? -4'sd8 : CNT_W'(7 - i);
      n_cmp++; if (count !== e) begin n_fail++; $display("FAIL dec_%0d got %0d want %0d", i, count, e); end
    end
  endtask

  task automatic test_bounce;
    repeat (15) begin
      usr_btn[1] = ~usr_btn[1];
      wait_cyc(2);
    end
    usr_btn = 4'b0000;
    wait_cyc(20);
    n_cmp++; if (count !== -4'sd8) begin n_fail++; $display("FAIL bounce got %0d want -8", count); end
    // one cycle short of the debounce window
    usr_btn[1] = 1'b1;
    wait_cyc(DEBOUNCE_CYC - 1);
    usr_btn[1] = 1'b0;
    wait_cyc(20);
    n_cmp++; if (count !== -4'sd8) begin n_fail++; $display("FAIL short_hold got %0d want -8", count); end
    // exactly the debounce window
    usr_btn[1] = 1'b1;
    wait_cyc(DEBOUNCE_CYC);
    usr_btn[1] = 1'b0;
    wait_cyc(20);
    n_cmp++; if (count !== -4'sd7) begin n_fail++; $display("FAIL exact_hold got %0d want -7", count); end
  endtask

  task automatic test_simultaneous;
    press(4'b0011);
    n_cmp++; if (count !== -4'sd7) begin n_fail++; $display("FAIL inc_dec_same got %0d want -7", count); end
  endtask

  task automatic test_brightness;
    int exp_duty [5] = '{5, 10, 15, 20, 20};
    int d, ones, zeros, lit, waited;
    logic [BR_W-1:0] eb;
    for (int i = 0; i < 5; i++) begin
      press(4'b1000);
      eb = (i + 1 > 4) ? 3'd4 : BR_W'(i + 1);
      n_cmp++; if (brightness !== eb) begin n_fail++; $display("FAIL brt_%0d got %0d want %0d", i, brightness, eb); end
      wait_cyc(40);
      duty(d);
      n_cmp++; if (d != exp_duty[i]) begin n_fail++; $display("FAIL duty_%0d got %0d want %0d", i, d, exp_duty[i]); end
    end
    n_cmp++; if (usr_led !== 4'b1001) begin n_fail++; $display("FAIL led_full got %b want 1001", usr_led); end

    // dim from 4 to 3: the current period must finish fully lit
    usr_btn = 4'b0100;
    waited = 0;
    while (brightness !== 3'd3 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    usr_btn = 4'b0000;
    n_cmp++; if (brightness !== 3'd3) begin n_fail++; $display("FAIL dim_wait got %0d want 3", brightness); end
    ones = 0;
    while (pwm_on === 1'b1 && ones < 60) begin
      ones++;
      @(negedge clk);
    end
    zeros = 0;
    while (pwm_on === 1'b0 && zeros < 60) begin
      zeros++;
      @(negedge clk);
    end
    n_cmp++; if (ones < 15 || ones > 35) begin n_fail++; $display("FAIL midperiod_on got %0d want 15..35", ones); end
    n_cmp++; if (zeros != 5) begin n_fail++; $display("FAIL first_off_run got %0d want 5", zeros); end
    wait_cyc(25);
    lit = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      if (usr_led === 4'b1001) lit++;
    end
    n_cmp++; if (lit != 15) begin n_fail++; $display("FAIL led_lit_level3 got %0d want 15", lit); end

    press(4'b1100);
    n_cmp++; if (brightness !== 3'd3) begin n_fail++; $display("FAIL dim_brt_same got %0d want 3", brightness); end
  endtask

  task automatic test_reset_mid;
    repeat (10) press(4'b0010);
    press(4'b0100);
    n_cmp++; if (count !== 4'sd3) begin n_fail++; $display("FAIL pre_reset_count got %0d want 3", count); end
    n_cmp++; if (brightness !== 3'd2) begin n_fail++; $display("FAIL pre_reset_brt got %0d want 2", brightness); end
    wait_cyc(7);
    usr_btn = 4'b0010;
    wait_cyc(2);
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    n_cmp++; if (count !== 4'sd0) begin n_fail++; $display("FAIL mid_reset_count got %0d want 0", count); end
    n_cmp++; if (brightness !== 3'd0) begin n_fail++; $display("FAIL mid_reset_brt got %0d want 0", brightness); end
    n_cmp++; if (usr_led !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_led got %b want 0000", usr_led); end
    n_cmp++; if (pwm_on !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pwm got %b want 0", pwm_on); end
    wait_cyc(30);
    n_cmp++; if (count !== 4'sd0) begin n_fail++; $display("FAIL held_thru_reset got %0d want 0", count); end
    usr_btn = 4'b0000;
    wait_cyc(15);
    n_cmp++; if (count !== 4'sd0) begin n_fail++; $display("FAIL release_no_pulse got %0d want 0", count); end
    press(4'b0010);
    n_cmp++; if (count !== 4'sd1) begin n_fail++; $display("FAIL repress got %0d want 1", count); end
  endtask

  initial begin
    reset_n = 1'b0;
    usr_btn = 4'b0000;
    test_reset;
    test_count_sat;
    test_bounce;
    test_simultaneous;
    test_brightness;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
